// File: rtl/telemetry_pkg.sv
// Shared telemetry link constants and the receive parser state encoding.
// The transmitter can import the same framing bytes.
package telemetry_pkg;

  localparam logic [7:0] SYNC_BYTE0    = 8'hAA;
  localparam logic [7:0] SYNC_BYTE1    = 8'h55;
  localparam int         PAYLOAD_BYTES = 6;

  typedef enum logic [2:0] {
    SYNC1,
    SYNC2,
    P1,
    P2,
    P3,
    P4,
    P5,
    P6
  } rx_state_e;

  // High payload bytes carry a 4-bit field; the upper nibble must be zero.
  function automatic logic hi_nibble_ok(input logic [7:0] b);
    return (b[7:4] == 4'h0);
  endfunction

endpackage

// File: rtl/telemetry_rx_uart_rx.sv
// 8N1 UART byte receiver: two-flop line synchronizer, mid-bit sampling,
// rdy held until the consumer pulses clr_rdy or a new start bit arrives.
module UART_rx #(
  parameter int BIT_CYC = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy
);

  localparam int CNT_W = $clog2(BIT_CYC + 1);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BIT_CYC / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BIT_CYC - 1);

  typedef enum logic {IDLE, RECV} uart_state_e;

  uart_state_e      state_q, state_d;
  logic             rx_meta_q, rx_meta_d;
  logic             rx_sync_q, rx_sync_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [3:0]       bit_q, bit_d;
  logic [8:0]       shift_q, shift_d;
  logic             rdy_q, rdy_d;

  always_comb begin
    state_d   = state_q;
    rx_meta_d = RX;
    rx_sync_d = rx_meta_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    rdy_d     = rdy_q;
    if (clr_rdy) rdy_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_sync_q) begin
          state_d = RECV;
          baud_d  = HALF_LOAD;
          bit_d   = 4'd0;
          rdy_d   = 1'b0;
        end
      end
      RECV: begin
        // Ten samples: start, eight data bits LSB first, stop.
        if (baud_q == '0) begin
          shift_d = {rx_sync_q, shift_q[8:1]};
          baud_d  = FULL_LOAD;
          bit_d   = bit_q + 4'd1;
          if (bit_q == 4'd9) begin
            state_d = IDLE;
            rdy_d   = 1'b1;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      baud_q    <= '0;
      bit_q     <= 4'd0;
      shift_q   <= 9'd0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_meta_q <= rx_meta_d;
      rx_sync_q <= rx_sync_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      rdy_q     <= rdy_d;
    end
  end

  assign rx_data = shift_q[7:0];
  assign rdy     = rdy_q;

endmodule

// File: rtl/telemetry_rx.sv
// Telemetry receiver: parses AA 55 + six payload bytes from UART_rx into
// shadow registers and commits all three measurements atomically.
module telemetry_rx
  import telemetry_pkg::*;
#(
  parameter int TIMEOUT_CYC = 131072,
  parameter int BIT_CYC     = 2604
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic [11:0] batt_v,
  output logic [11:0] avg_curr,
  output logic [11:0] avg_torque,
  output logic        pkt_vld,
  output logic        pkt_err,
  output logic [7:0]  pkt_cnt
);

  localparam int GAP_W = $clog2(TIMEOUT_CYC);
  localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(TIMEOUT_CYC - 1);

  logic [7:0] rx_data;
  logic       rdy;
  logic       clr_rdy;

  UART_rx #(.BIT_CYC(BIT_CYC)) u_uart_rx (
    .clk     (clk),
    .rst_n   (rst_n),
    .RX      (RX),
    .clr_rdy (clr_rdy),
    .rx_data (rx_data),
    .rdy     (rdy)
  );

  // Every state consumes the byte it sees, so the handshake is just rdy.
  assign clr_rdy = rdy;

  rx_state_e        state_q, state_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [3:0]       sh_batt_hi_q, sh_batt_hi_d;
  logic [7:0]       sh_batt_lo_q, sh_batt_lo_d;
  logic [3:0]       sh_curr_hi_q, sh_curr_hi_d;
  logic [7:0]       sh_curr_lo_q, sh_curr_lo_d;
  logic [3:0]       sh_torq_hi_q, sh_torq_hi_d;
  logic [11:0]      batt_v_q, batt_v_d;
  logic [11:0]      avg_curr_q, avg_curr_d;
  logic [11:0]      avg_torque_q, avg_torque_d;
  logic             pkt_vld_q, pkt_vld_d;
  logic             pkt_err_q, pkt_err_d;
  logic [7:0]       pkt_cnt_q, pkt_cnt_d;

  always_comb begin
    state_d      = state_q;
    gap_d        = gap_q;
    sh_batt_hi_d = sh_batt_hi_q;
    sh_batt_lo_d = sh_batt_lo_q;
    sh_curr_hi_d = sh_curr_hi_q;
    sh_curr_lo_d = sh_curr_lo_q;
    sh_torq_hi_d = sh_torq_hi_q;
    batt_v_d     = batt_v_q;
    avg_curr_d   = avg_curr_q;
    avg_torque_d = avg_torque_q;
    pkt_vld_d    = 1'b0;
    pkt_err_d    = 1'b0;
    pkt_cnt_d    = pkt_cnt_q;
    if (rdy) begin
      gap_d = '0;
      case (state_q)
        SYNC1: if (rx_data == SYNC_BYTE0) state_d = SYNC2;
        SYNC2: begin
          if (rx_data == SYNC_BYTE1) begin
            state_d = P1;
          end else if (rx_data != SYNC_BYTE0) begin
            state_d   = SYNC1;
            pkt_err_d = 1'b1;
          end
        end
        P1, P3, P5: begin
          if (hi_nibble_ok(rx_data)) begin
            if (state_q == P1) sh_batt_hi_d = rx_data[3:0];
            if (state_q == P3) sh_curr_hi_d = rx_data[3:0];
            if (state_q == P5) sh_torq_hi_d = rx_data[3:0];
            state_d = rx_state_e'(state_q + 3'd1);
          end else begin
            state_d   = SYNC1;
            pkt_err_d = 1'b1;
          end
        end
        P2: begin
          sh_batt_lo_d = rx_data;
          state_d      = P3;
        end
        P4: begin
          sh_curr_lo_d = rx_data;
          state_d      = P5;
        end
        P6: begin
          batt_v_d     = {sh_batt_hi_q, sh_batt_lo_q};
          avg_curr_d   = {sh_curr_hi_q, sh_curr_lo_q};
          avg_torque_d = {sh_torq_hi_q, rx_data};
          pkt_vld_d    = 1'b1;
          pkt_cnt_d    = pkt_cnt_q + 8'd1;
          state_d      = SYNC1;
        end
        default: state_d = SYNC1;
      endcase
    end else if (state_q == SYNC1) begin
      gap_d = '0;
    end else if (gap_q == GAP_LIMIT) begin
      gap_d     = '0;
      state_d   = SYNC1;
      pkt_err_d = 1'b1;
    end else begin
      gap_d = gap_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= SYNC1;
      gap_q        <= '0;
      sh_batt_hi_q <= 4'd0;
      sh_batt_lo_q <= 8'd0;
      sh_curr_hi_q <= 4'd0;
      sh_curr_lo_q <= 8'd0;
      sh_torq_hi_q <= 4'd0;
      batt_v_q     <= 12'd0;
      avg_curr_q   <= 12'd0;
      avg_torque_q <= 12'd0;
      pkt_vld_q    <= 1'b0;
      pkt_err_q    <= 1'b0;
      pkt_cnt_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      gap_q        <= gap_d;
      sh_batt_hi_q <= sh_batt_hi_d;
      sh_batt_lo_q <= sh_batt_lo_d;
      sh_curr_hi_q <= sh_curr_hi_d;
      sh_curr_lo_q <= sh_curr_lo_d;
      sh_torq_hi_q <= sh_torq_hi_d;
      batt_v_q     <= batt_v_d;
      avg_curr_q   <= avg_curr_d;
      avg_torque_q <= avg_torque_d;
      pkt_vld_q    <= pkt_vld_d;
      pkt_err_q    <= pkt_err_d;
      pkt_cnt_q    <= pkt_cnt_d;
    end
  end

  assign batt_v     = batt_v_q;
  assign avg_curr   = avg_curr_q;
  assign avg_torque = avg_torque_q;
  assign pkt_vld    = pkt_vld_q;
  assign pkt_err    = pkt_err_q;
  assign pkt_cnt    = pkt_cnt_q;

endmodule

// File: tb/tb_telemetry_rx.sv
// Bench for telemetry_rx: serial packets driven on RX, good packets scored
// through an expectation queue, error pulses counted per scenario.
module tb_telemetry_rx;

  localparam int BIT_CYC     = 3;
  localparam int TIMEOUT_CYC = 1000;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX    = 1'b1;
  logic [11:0] batt_v, avg_curr, avg_torque;
  logic        pkt_vld, pkt_err;
  logic [7:0]  pkt_cnt;

  always #5 clk = ~clk;

  telemetry_rx #(.TIMEOUT_CYC(TIMEOUT_CYC), .BIT_CYC(BIT_CYC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .RX         (RX),
    .batt_v     (batt_v),
    .avg_curr   (avg_curr),
    .avg_torque (avg_torque),
    .pkt_vld    (pkt_vld),
    .pkt_err    (pkt_err),
    .pkt_cnt    (pkt_cnt)
  );

  typedef struct {
    logic [11:0] b;
    logic [11:0] c;
    logic [11:0] t;
    logic [7:0]  cnt;
  } exp_pkt_t;

  typedef struct {
    logic [63:0] bytes;
    logic        good;
    logic [11:0] b;
    logic [11:0] c;
    logic [11:0] t;
    int          errs;
  } vec_t;

  exp_pkt_t    exp_q[$];
  exp_pkt_t    got;
  vec_t        vecs[8];
  int          checks   = 0;
  int          passes   = 0;
  int          vld_seen = 0;
  int          err_seen = 0;
  logic [11:0] good_b = 12'd0, good_c = 12'd0, good_t = 12'd0;
  logic [7:0]  exp_cnt = 8'd0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic v);
    @(negedge clk);
    RX = v;
    repeat (BIT_CYC - 1) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(1'b1);
  endtask

  task automatic expect_good(input logic [11:0] b, input logic [11:0] c, input logic [11:0] t);
    exp_pkt_t e;
    exp_cnt = exp_cnt + 8'd1;
    e.b = b; e.c = c; e.t = t; e.cnt = exp_cnt;
    exp_q.push_back(e);
    good_b = b; good_c = c; good_t = t;
  endtask

  task automatic send_packet(input logic [11:0] b, input logic [11:0] c, input logic [11:0] t);
    expect_good(b, c, t);
    send_byte(8'hAA); send_byte(8'h55);
    send_byte({4'h0, b[11:8]}); send_byte(b[7:0]);
    send_byte({4'h0, c[11:8]}); send_byte(c[7:0]);
    send_byte({4'h0, t[11:8]}); send_byte(t[7:0]);
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.good) expect_good(v.b, v.c, v.t);
    for (int i = 0; i < 8; i++) send_byte(v.bytes[63-8*i -: 8]);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    exp_cnt = 8'd0;
    good_b = 12'd0; good_c = 12'd0; good_t = 12'd0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_held(input string tag);
    checkOutput({tag, "_pending"}, exp_q.size(), 0);
    checkOutput({tag, "_batt_v"}, int'(batt_v), int'(good_b));
    checkOutput({tag, "_avg_curr"}, int'(avg_curr), int'(good_c));
    checkOutput({tag, "_avg_torque"}, int'(avg_torque), int'(good_t));
    checkOutput({tag, "_pkt_cnt"}, int'(pkt_cnt), int'(exp_cnt));
  endtask

  // Scoreboard: each pkt_vld pops one expected packet; errors are tallied.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pkt_vld) begin
        vld_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          $display("[TB] FAIL unexpected_vld: got pkt_vld with batt_v=0x%0h, required no packet", batt_v);
        end else begin
          got = exp_q.pop_front();
          checkOutput("sb_batt_v", int'(batt_v), int'(got.b));
          checkOutput("sb_avg_curr", int'(avg_curr), int'(got.c));
          checkOutput("sb_avg_torque", int'(avg_torque), int'(got.t));
          checkOutput("sb_pkt_cnt", int'(pkt_cnt), int'(got.cnt));
        end
      end
      if (pkt_err) begin
        err_seen++;
        checkOutput("err_excludes_vld", int'(pkt_vld), 0);
      end
    end
  end

  initial begin
    int e0, v0;
    vecs[0] = '{64'hAA55_0ABC_0123_0FFF, 1'b1, 12'hABC, 12'h123, 12'hFFF, 0};
    vecs[1] = '{64'hAA55_0000_0000_0000, 1'b1, 12'h000, 12'h000, 12'h000, 0};
    vecs[2] = '{64'hAA55_1ABC_0123_0FFF, 1'b0, 12'h000, 12'h000, 12'h000, 1};
    vecs[3] = '{64'hAA55_0555_0AAA_0777, 1'b1, 12'h555, 12'hAAA, 12'h777, 0};
    vecs[4] = '{64'hAA12_0000_0000_0000, 1'b0, 12'h000, 12'h000, 12'h000, 1};
    vecs[5] = '{64'hAA55_0102_F304_0506, 1'b0, 12'h000, 12'h000, 12'h000, 1};
    vecs[6] = '{64'hAA55_0102_0304_8006, 1'b0, 12'h000, 12'h000, 12'h000, 1};
    vecs[7] = '{64'hAA55_0FFF_0FFF_0FFF, 1'b1, 12'hFFF, 12'hFFF, 12'hFFF, 0};

    settle(4);
    checkOutput("rst_batt_v", int'(batt_v), 0);
    checkOutput("rst_avg_curr", int'(avg_curr), 0);
    checkOutput("rst_avg_torque", int'(avg_torque), 0);
    checkOutput("rst_pkt_vld", int'(pkt_vld), 0);
    checkOutput("rst_pkt_err", int'(pkt_err), 0);
    checkOutput("rst_pkt_cnt", int'(pkt_cnt), 0);
    rst_n = 1'b1;
    settle(4);

    for (int i = 0; i < 8; i++) begin
      e0 = err_seen;
      applyStimulus(vecs[i]);
      settle(12);
      checkOutput($sformatf("vec%0d_errs", i), err_seen - e0, vecs[i].errs);
      check_held($sformatf("vec%0d", i));
    end

    $display("[TB] garbage before sync");
    e0 = err_seen;
    send_byte(8'h00); send_byte(8'h55); send_byte(8'hAA); send_byte(8'hAA); send_byte(8'h55);
    expect_good(12'hABC, 12'h123, 12'hFFF);
    send_byte(8'h0A); send_byte(8'hBC); send_byte(8'h01);
    send_byte(8'h23); send_byte(8'h0F); send_byte(8'hFF);
    settle(12);
    checkOutput("garbage_errs", err_seen - e0, 0);
    check_held("garbage");

    $display("[TB] inter-byte timeout");
    e0 = err_seen;
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h0A);
    settle(TIMEOUT_CYC + 100);
    checkOutput("timeout_errs", err_seen - e0, 1);
    check_held("timeout");
    send_packet(12'h321, 12'h654, 12'h987);
    settle(12);
    checkOutput("after_timeout_errs", err_seen - e0, 1);
    check_held("after_timeout");

    $display("[TB] reset mid-packet");
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    settle(6);
    pulse_reset();
    #1;
    checkOutput("midrst_batt_v", int'(batt_v), 0);
    checkOutput("midrst_avg_curr", int'(avg_curr), 0);
    checkOutput("midrst_avg_torque", int'(avg_torque), 0);
    checkOutput("midrst_pkt_cnt", int'(pkt_cnt), 0);
    e0 = err_seen;
    v0 = vld_seen;
    send_byte(8'h04); send_byte(8'h05); send_byte(8'h06);
    settle(12);
    checkOutput("midrst_tail_vld", vld_seen - v0, 0);
    checkOutput("midrst_tail_errs", err_seen - e0, 0);
    send_packet(12'h0F0, 12'h00F, 12'hF00);
    settle(12);
    check_held("midrst_next");

    $display("[TB] 256 back-to-back packets");
    pulse_reset();
    v0 = vld_seen;
    e0 = err_seen;
    for (int i = 0; i < 256; i++)
      send_packet(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)),
                  12'($urandom_range(0, 4095)));
    settle(12);
    checkOutput("b2b_vld_count", vld_seen - v0, 256);
    checkOutput("b2b_errs", err_seen - e0, 0);
    checkOutput("b2b_cnt_wrap", int'(pkt_cnt), 0);
    check_held("b2b");

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
